// File: rtl/dnn_engine_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dnn_engine_ctrl
//
// Run controller between the DMA input streams (pixels, weights) and the DNN
// engine. A start pulse latches the run configuration and then admits exactly
// cfg_n_iters pixel packets and cfg_n_iters weight packets, one of each per
// iteration. Output packets leaving the engine are counted from a monitor tap.
// When the last input iteration has been admitted the controller drains until
// all output packets have been seen, then pulses done. A stall watchdog moves
// the controller into an error state when no stream moves for too long.
//
// Only valid/ready are gated here; tdata/tkeep/tlast go straight from the DMA
// to the engine in the parent.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   start                    1-cycle run request (honoured in IDLE/DONE/ERR)
//   cfg_n_iters              iterations in the run, latched on accepted start
//   cfg_timeout              stall limit in cycles (0 disables), latched
//   busy                     high while running or draining
//   done                     1-cycle pulse when the run has completed
//   err_timeout              sticky stall-timeout flag
//   iters_in                 completed input iterations this run
//   pkts_out                 output packets observed this run
//   s_pix_* / m_pix_*        pixel stream, DMA side / engine side
//   s_wgt_* / m_wgt_*        weight stream, DMA side / engine side
//   out_tvalid/tready/tlast  observe-only taps of the engine output stream
// ---------------------------------------------------------------------------
module dnn_engine_ctrl #(
  parameter int ITER_W = 16,
  parameter int TO_W   = 24
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ITER_W-1:0] cfg_n_iters,
  input  logic [TO_W-1:0]   cfg_timeout,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [ITER_W-1:0] iters_in,
  output logic [ITER_W-1:0] pkts_out,
  input  logic              s_pix_tvalid,
  input  logic              s_pix_tlast,
  output logic              s_pix_tready,
  output logic              m_pix_tvalid,
  input  logic              m_pix_tready,
  input  logic              s_wgt_tvalid,
  input  logic              s_wgt_tlast,
  output logic              s_wgt_tready,
  output logic              m_wgt_tvalid,
  input  logic              m_wgt_tready,
  input  logic              out_tvalid,
  input  logic              out_tready,
  input  logic              out_tlast
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] n_q, n_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] pkts_q, pkts_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              pix_open_q, pix_open_d;
  logic              wgt_open_q, wgt_open_d;

  logic              pix_hs, pix_end;
  logic              wgt_hs, wgt_end;
  logic              out_hs, out_end;
  logic              any_hs;
  logic              active;
  logic              start_ok;
  logic              timeout_hit;
  logic              pix_done, wgt_done, iter_done;
  logic [ITER_W-1:0] iters_next;

  // Zero-latency gating: a closed window hides valid from the engine and
  // ready from the DMA, so no beat can move while it is closed.
  assign m_pix_tvalid = s_pix_tvalid & pix_open_q;
  assign s_pix_tready = m_pix_tready & pix_open_q;
  assign m_wgt_tvalid = s_wgt_tvalid & wgt_open_q;
  assign s_wgt_tready = m_wgt_tready & wgt_open_q;

  assign pix_hs  = s_pix_tvalid & s_pix_tready;
  assign pix_end = pix_hs & s_pix_tlast;
  assign wgt_hs  = s_wgt_tvalid & s_wgt_tready;
  assign wgt_end = wgt_hs & s_wgt_tlast;
  assign out_hs  = out_tvalid & out_tready;
  assign out_end = out_hs & out_tlast;
  assign any_hs  = pix_hs | wgt_hs | out_hs;

  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));

  // The watchdog fires on the last stalled cycle of the allowed budget, so
  // the error state appears exactly cfg_timeout cycles after the last beat.
  assign timeout_hit = active && (to_q != '0) && !any_hs &&
                       (timer_q == (to_q - TO_W'(1)));

  // A stream has delivered its packet for the current iteration either by
  // ending it now or by having ended it earlier (its window is then closed).
  assign pix_done   = pix_end | ~pix_open_q;
  assign wgt_done   = wgt_end | ~wgt_open_q;
  assign iter_done  = (pix_end | wgt_end) & pix_done & wgt_done;
  assign iters_next = iters_q + ITER_W'(1);

  assign busy        = active;
  assign done        = (state_q == ST_DONE);
  assign err_timeout = (state_q == ST_ERR);
  assign iters_in    = iters_q;
  assign pkts_out    = pkts_q;

  // Next-state logic. Counters and the watchdog are updated first, then the
  // state machine, and an accepted start overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    to_d       = to_q;
    iters_d    = iters_q;
    pkts_d     = pkts_q;
    timer_d    = timer_q;
    pix_open_d = pix_open_q;
    wgt_open_d = wgt_open_q;

    if (active && out_end) begin
      pkts_d = pkts_q + ITER_W'(1);
    end

    if (any_hs) begin
      timer_d = '0;
    end else if (active && (timer_q != '1)) begin
      timer_d = timer_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
      end

      ST_RUN: begin
        if (iter_done) begin
          iters_d = iters_next;
          if (iters_next < n_q) begin
            // Reopen both windows in the same edge so the next iteration
            // starts without a bubble.
            pix_open_d = 1'b1;
            wgt_open_d = 1'b1;
          end else begin
            pix_open_d = 1'b0;
            wgt_open_d = 1'b0;
            state_d    = ST_DRAIN;
          end
        end else begin
          if (pix_end) pix_open_d = 1'b0;
          if (wgt_end) wgt_open_d = 1'b0;
          if (timeout_hit) begin
            pix_open_d = 1'b0;
            wgt_open_d = 1'b0;
            state_d    = ST_ERR;
          end
        end
      end

      ST_DRAIN: begin
        // Using the updated count lets done follow the final output packet
        // by a single cycle.
        if (pkts_d == n_q) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
      end

      default: begin
        state_d    = ST_IDLE;
        pix_open_d = 1'b0;
        wgt_open_d = 1'b0;
      end
    endcase

    if (start_ok) begin
      n_d     = cfg_n_iters;
      to_d    = cfg_timeout;
      iters_d = '0;
      pkts_d  = '0;
      timer_d = '0;
      if (cfg_n_iters == '0) begin
        state_d    = ST_DONE;
        pix_open_d = 1'b0;
        wgt_open_d = 1'b0;
      end else begin
        state_d    = ST_RUN;
        pix_open_d = 1'b1;
        wgt_open_d = 1'b1;
      end
    end
  end

  // State and counter registers with synchronous active-low reset; the
  // windows close at the reset edge even in the middle of a packet.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      to_q       <= '0;
      iters_q    <= '0;
      pkts_q     <= '0;
      timer_q    <= '0;
      pix_open_q <= 1'b0;
      wgt_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      to_q       <= to_d;
      iters_q    <= iters_d;
      pkts_q     <= pkts_d;
      timer_q    <= timer_d;
      pix_open_q <= pix_open_d;
      wgt_open_q <= wgt_open_d;
    end
  end

endmodule

// File: tb/tb_dnn_engine_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dnn_engine_ctrl
//
// Directed bench for dnn_engine_ctrl. Simple DMA sources offer packets of a
// configurable length; the engine output tap is pulsed by hand. A run-level
// model tracks how many pixel/weight packets have ended and how many output
// packets were seen, and derives the window and status outputs from those
// counts every cycle. Scenario code adds hand-computed cycle-exact checks.
// ---------------------------------------------------------------------------
module tb_dnn_engine_ctrl;

  localparam int ITER_W = 16;
  localparam int TO_W   = 24;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;
  localparam int M_ERR   = 4;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              start = 1'b0;
  logic [ITER_W-1:0] cfg_n_iters = '0;
  logic [TO_W-1:0]   cfg_timeout = '0;
  logic              busy, done, err_timeout;
  logic [ITER_W-1:0] iters_in, pkts_out;
  logic              s_pix_tvalid = 1'b0, s_pix_tlast = 1'b0, m_pix_tready = 1'b1;
  logic              s_pix_tready, m_pix_tvalid;
  logic              s_wgt_tvalid = 1'b0, s_wgt_tlast = 1'b0, m_wgt_tready = 1'b1;
  logic              s_wgt_tready, m_wgt_tvalid;
  logic              out_tvalid = 1'b0, out_tready = 1'b1, out_tlast = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  int pix_left = 0, pix_len = 1, pix_beat = 0, pix_beats = 0;
  int wgt_left = 0, wgt_len = 1, wgt_beat = 0, wgt_beats = 0;

  int md = M_IDLE, mn = 0, mto = 0, mpix = 0, mwgt = 0, mpkts = 0, mstall = 0;
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  dnn_engine_ctrl #(.ITER_W(ITER_W), .TO_W(TO_W)) dut (
    .aclk(clk), .aresetn(aresetn), .start(start),
    .cfg_n_iters(cfg_n_iters), .cfg_timeout(cfg_timeout),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .iters_in(iters_in), .pkts_out(pkts_out),
    .s_pix_tvalid(s_pix_tvalid), .s_pix_tlast(s_pix_tlast), .s_pix_tready(s_pix_tready),
    .m_pix_tvalid(m_pix_tvalid), .m_pix_tready(m_pix_tready),
    .s_wgt_tvalid(s_wgt_tvalid), .s_wgt_tlast(s_wgt_tlast), .s_wgt_tready(s_wgt_tready),
    .m_wgt_tvalid(m_wgt_tvalid), .m_wgt_tready(m_wgt_tready),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a stream window is open while running and that stream
  // is not already a packet ahead of the other one.
  function automatic bit model_pix_open();
    return (md == M_RUN) && (mpix <= mwgt);
  endfunction

  function automatic bit model_wgt_open();
    return (md == M_RUN) && (mwgt <= mpix);
  endfunction

  // Advance the model with the inputs of the cycle that just ended.
  always @(posedge clk) begin : model_update
    automatic bit ph, pe, wh, we, oh, oe, act;
    if (!aresetn) begin
      md = M_IDLE; mn = 0; mto = 0; mpix = 0; mwgt = 0; mpkts = 0; mstall = 0;
      mvalid = 1'b1;
    end else begin
      ph  = s_pix_tvalid && m_pix_tready && model_pix_open();
      pe  = ph && s_pix_tlast;
      wh  = s_wgt_tvalid && m_wgt_tready && model_wgt_open();
      we  = wh && s_wgt_tlast;
      oh  = out_tvalid && out_tready;
      oe  = oh && out_tlast;
      act = (md == M_RUN) || (md == M_DRAIN);
      if (start && ((md == M_IDLE) || (md == M_DONE) || (md == M_ERR))) begin
        mn = int'(cfg_n_iters); mto = int'(cfg_timeout);
        mpix = 0; mwgt = 0; mpkts = 0; mstall = 0;
        md = (mn == 0) ? M_DONE : M_RUN;
      end else if (md == M_DONE) begin
        md = M_IDLE;
      end else if (act) begin
        if (oe) mpkts++;
        if (pe) mpix++;
        if (we) mwgt++;
        if (ph || wh || oh) mstall = 0; else mstall++;
        if ((md == M_RUN) && (imin(mpix, mwgt) == mn)) md = M_DRAIN;
        else if ((md == M_DRAIN) && (mpkts == mn)) md = M_DONE;
        else if ((mto != 0) && (mstall >= mto)) md = M_ERR;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin : model_compare
    if (mvalid) begin
      checkOutput("busy", busy, (md == M_RUN) || (md == M_DRAIN));
      checkOutput("done", done, md == M_DONE);
      checkOutput("err_timeout", err_timeout, md == M_ERR);
      checkOutput("iters_in", iters_in, imin(mpix, mwgt));
      checkOutput("pkts_out", pkts_out, mpkts);
      checkOutput("m_pix_tvalid", m_pix_tvalid, s_pix_tvalid && model_pix_open());
      checkOutput("s_pix_tready", s_pix_tready, m_pix_tready && model_pix_open());
      checkOutput("m_wgt_tvalid", m_wgt_tvalid, s_wgt_tvalid && model_wgt_open());
      checkOutput("s_wgt_tready", s_wgt_tready, m_wgt_tready && model_wgt_open());
    end
  end

  task automatic applyStimulus();
    s_pix_tvalid = (pix_left > 0);
    s_pix_tlast  = (pix_beat == pix_len - 1);
    s_wgt_tvalid = (wgt_left > 0);
    s_wgt_tlast  = (wgt_beat == wgt_len - 1);
  endtask

  // Finish the current cycle: note which beats moved, then advance the
  // sources and present the next cycle's inputs 1 ns after the edge.
  task automatic tick();
    bit pix_seen, wgt_seen;
    @(negedge clk);
    pix_seen = s_pix_tvalid && s_pix_tready;
    wgt_seen = s_wgt_tvalid && s_wgt_tready;
    if (pix_seen) pix_beats++;
    if (wgt_seen) wgt_beats++;
    @(posedge clk);
    #1;
    if (pix_seen) begin
      if (pix_beat == pix_len - 1) begin pix_beat = 0; pix_left--; end
      else pix_beat++;
    end
    if (wgt_seen) begin
      if (wgt_beat == wgt_len - 1) begin wgt_beat = 0; wgt_left--; end
      else wgt_beat++;
    end
    start      = 1'b0;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    applyStimulus();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic setSources(input int pl, input int plen, input int wl, input int wlen);
    pix_left = pl; pix_len = plen; pix_beat = 0; pix_beats = 0;
    wgt_left = wl; wgt_len = wlen; wgt_beat = 0; wgt_beats = 0;
    applyStimulus();
  endtask

  // Start pulse; afterwards the config inputs are scrambled so that only the
  // latched copy can explain the behaviour of the run.
  task automatic doStart(input int n, input int to);
    cfg_n_iters = ITER_W'(n);
    cfg_timeout = TO_W'(to);
    start = 1'b1;
    tick();
    cfg_n_iters = ITER_W'(7);
    cfg_timeout = TO_W'(3);
  endtask

  task automatic pulseOut(input bit last);
    out_tvalid = 1'b1;
    out_tlast  = last;
  endtask

  task automatic waitDone(input string name, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    checkOutput(name, done, 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err_timeout", err_timeout, 0);
    checkOutput("reset iters_in", iters_in, 0);
    checkOutput("reset pkts_out", pkts_out, 0);
    tick();

    // n=3: 4-beat pixel and 2-beat weight packets back to back.
    setSources(3, 4, 3, 2);
    doStart(3, 0);
    ticks(2);
    pulseOut(1'b0);
    tick();
    ticks(2);
    pulseOut(1'b1);
    tick();
    ticks(3);
    pulseOut(1'b1);
    tick();
    ticks(2);
    checkOutput("s1 iters_in in drain", iters_in, 3);
    checkOutput("s1 busy in drain", busy, 1);
    tick();
    pulseOut(1'b1);
    tick();
    checkOutput("s1 done after last out", done, 1);
    checkOutput("s1 pkts_out", pkts_out, 3);
    tick();
    checkOutput("s1 done pulse width", done, 0);
    checkOutput("s1 busy after", busy, 0);
    checkOutput("s1 pixel beats", pix_beats, 12);
    checkOutput("s1 weight beats", wgt_beats, 6);
    ticks(2);

    // n=2: weight packet ends cycle 5, pixel packet ends cycle 9.
    setSources(2, 9, 2, 5);
    doStart(2, 0);
    ticks(5);
    for (int c = 6; c <= 9; c++) begin
      checkOutput($sformatf("s2 wgt closed c%0d", c), s_wgt_tready, 0);
      tick();
    end
    checkOutput("s2 wgt reopened c10", s_wgt_tready, 1);
    checkOutput("s2 iters_in c10", iters_in, 1);
    pulseOut(1'b1);
    ticks(2);
    pulseOut(1'b1);
    tick();
    waitDone("s2 run completes", 40);
    checkOutput("s2 iters_in final", iters_in, 2);
    ticks(2);

    // n=1 with a second pixel packet offered.
    setSources(2, 3, 1, 2);
    doStart(1, 0);
    ticks(3);
    for (int c = 4; c <= 7; c++) begin
      checkOutput($sformatf("s3 pix closed c%0d", c), s_pix_tready, 0);
      checkOutput($sformatf("s3 draining c%0d", c), busy, 1);
      tick();
    end
    pulseOut(1'b1);
    tick();
    checkOutput("s3 done", done, 1);
    checkOutput("s3 pixel beats", pix_beats, 3);
    setSources(0, 1, 0, 1);
    ticks(2);

    // n=2, timeout=16, streams stall after the first iteration.
    setSources(1, 2, 1, 2);
    doStart(2, 16);
    ticks(17);
    checkOutput("s4 no err at 16 stalls", err_timeout, 0);
    checkOutput("s4 busy before err", busy, 1);
    tick();
    checkOutput("s4 err after 16 stalls", err_timeout, 1);
    checkOutput("s4 busy in err", busy, 0);
    setSources(1, 2, 1, 2);
    #1;
    checkOutput("s4 pix closed in err", s_pix_tready, 0);
    checkOutput("s4 wgt valid hidden in err", m_wgt_tvalid, 0);
    ticks(3);
    checkOutput("s4 err sticky", err_timeout, 1);
    doStart(1, 16);
    checkOutput("s4 err cleared by start", err_timeout, 0);
    ticks(2);
    pulseOut(1'b1);
    tick();
    checkOutput("s4 rerun done", done, 1);
    ticks(2);

    // n=0 runs, back-to-back starts from DONE, outputs ignored when idle,
    // and a start while busy.
    setSources(1, 2, 1, 2);
    doStart(0, 0);
    checkOutput("s5 n0 done", done, 1);
    checkOutput("s5 n0 busy", busy, 0);
    doStart(0, 0);
    checkOutput("s5 start from done", done, 1);
    tick();
    checkOutput("s5 done cleared", done, 0);
    checkOutput("s5 no beats admitted", pix_beats + wgt_beats, 0);
    pulseOut(1'b1);
    tick();
    checkOutput("s5 idle out ignored", pkts_out, 0);
    doStart(1, 0);
    cfg_n_iters = ITER_W'(5);
    start = 1'b1;
    tick();
    checkOutput("s5 busy start ignored", busy, 1);
    tick();
    pulseOut(1'b1);
    tick();
    checkOutput("s5 done n1", done, 1);
    checkOutput("s5 iters_in n1", iters_in, 1);
    ticks(2);

    // Reset in the middle of a pixel packet.
    setSources(2, 3, 2, 2);
    m_pix_tready = 1'b0;
    doStart(2, 0);
    pulseOut(1'b1);
    tick();
    m_pix_tready = 1'b1;
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    setSources(0, 1, 0, 1);
    checkOutput("s6 reset busy", busy, 0);
    checkOutput("s6 reset iters_in", iters_in, 0);
    checkOutput("s6 reset pkts_out", pkts_out, 0);
    checkOutput("s6 reset pix window", s_pix_tready, 0);
    setSources(2, 3, 2, 2);
    ticks(3);
    checkOutput("s6 no resume without start", busy, 0);
    checkOutput("s6 no beats without start", pix_beats, 0);
    doStart(2, 0);
    pulseOut(1'b1);
    tick();
    pulseOut(1'b1);
    tick();
    waitDone("s6 run completes", 40);
    checkOutput("s6 iters_in", iters_in, 2);
    checkOutput("s6 pixel beats", pix_beats, 6);
    checkOutput("s6 weight beats", wgt_beats, 4);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
